execute_muldiv_stage: RTL and testbench
=======================================

Name: execute_muldiv_stage

Overview:
- Execute-stage extension that adds RV32M multiply/divide to the EX path and owns the EX/MEM pipeline register feeding memory_cycle.
- MUL* completes in the EX cycle; DIV*/REM* runs on an iterative radix-2 restoring divider that stalls the front end for 33 cycles.
- Base-ALU ops pass through unchanged.

Parameters:
- XLEN, 32, operand/result width.
- DIV_CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- RegWriteE, MemWriteE, ResultSrcE  in  1 each  ID/EX control
- RD_E  in  5  destination register
- PCPlus4E, WriteDataE, ALU_ResultE  in  32 each  ID/EX data; base ALU result
- SrcAE, SrcBE  in  32 each  forwarded operands
- MulDivE  in  1  EX instruction is RV32M
- MulDivOpE  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- FlushE  in  1  kill the EX instruction
- MemStallM  in  1  memory stage wait request; hold EX/MEM
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  EX/MEM control
- RD_M  out  5  EX/MEM destination
- PCPlus4M, WriteDataM, ALU_ResultM  out  32 each  EX/MEM data
- stall_o  out  1  freeze IF/ID/EX (ID/EX inputs held stable while high)

Behaviour:
- Reset: all EX/MEM outputs 0, FSM = IDLE, counter 0; stall_o = 0 unless MemStallM = 1.
- Result mux:
  - MulDivE = 0: ALU_ResultE.
  - MUL ops: low/high word of a 64-bit product computed combinationally. MULH treats both operands as signed, MULHSU treats A signed and B unsigned, MULHU treats both unsigned. Latency is the same as an ALU op.
  - DIV ops: divider output.
- FSM IDLE / RUN / DONE:
  - IDLE, divide op, no FlushE:
    - Special cases complete immediately with no stall; result loads on this edge:
      - divisor = 0: quotient 0xFFFFFFFF, remainder = dividend.
      - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
    - Otherwise:
      - stall_o = 1.
      - On the next edge, latch |A| and |B| (absolute values for signed ops, raw values for unsigned ops) plus the result signs, then go to RUN with cnt = 0.
  - RUN:
    - One shift/subtract iteration per edge; cnt increments.
    - On the edge with cnt = 31, go to DONE.
    - stall_o = 1 throughout.
  - DONE:
    - stall_o = 0 and the sign-corrected result is presented. Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
    - The EX/MEM load edge returns the FSM to IDLE.
  - Total: 33 stall cycles; result enters EX/MEM on the 34th edge after the op first appears.
- stall_o = div_busy OR MemStallM.
- EX/MEM register update, in priority order:
  1. MemStallM = 1: hold all values. The FSM advances through RUN but stays in DONE.
  2. FlushE = 1: load a bubble (RegWriteM = MemWriteM = ResultSrcM = 0; other fields don't-care but zeroed). The FSM aborts to IDLE from any state; the flush is never lost.
  3. stall_o = 1 (divider busy): load a bubble.
  4. Otherwise: load the EX values.
- Reset asserted mid-divide: immediate IDLE, outputs 0.
- Back-to-back divides: the second is accepted in the cycle after DONE.

Optional Feature:
- DIV_EARLY_OUT_EN defined: in IDLE, unsigned compare |A| < |B| finishes with no stall. DIV/DIVU give 0; REM/REMU give the dividend as-is.
- Not defined: such operands take the full 33-cycle path and produce identical results.

Test Plan:
- MUL 0xFFFFFFFF*0xFFFFFFFF: MUL=0x00000001, MULH=0x00000000, MULHU=0xFFFFFFFE, MULHSU=0xFFFFFFFF. Each appears in ALU_ResultM one edge after issue, stall_o = 0.
- DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIVU 100/7 gives 14. Each shows stall_o high for exactly 33 cycles and RegWriteM bubbles during the stall.
- DIV x/0 gives 0xFFFFFFFF; REMU 5/0 gives 5; DIV 0x80000000/-1 gives 0x80000000. All with zero stall cycles.
- FlushE pulsed at RUN cnt = 10: FSM returns to IDLE, a bubble enters EX/MEM, stall_o drops the next cycle.
- MemStallM held 3 cycles while in DONE: EX/MEM frozen, result is loaded only after MemStallM falls. Reset pulse during RUN: all outputs 0, FSM IDLE.
- With DIV_EARLY_OUT_EN: DIVU 3/9 gives 0 and REMU 3/9 gives 3, both with no stall. Without the macro: same values after a 33-cycle stall.

Source files
------------

// File: rtl/execute_muldiv_stage.sv
// execute_muldiv_stage: RV32M multiply/divide extension of the EX stage. It also owns the
// EX/MEM pipeline register that feeds memory_cycle.
//   - MUL/MULH/MULHSU/MULHU finish combinationally, with the same latency as a base ALU op.
//   - DIV/DIVU/REM/REMU use an iterative radix-2 restoring divider (IDLE -> RUN -> DONE).
//     While it is busy, stall_o is held high for 33 cycles.
//   - Divide by zero and signed overflow finish in IDLE and do not stall.
// Optional build macro: DIV_EARLY_OUT_EN. When it is defined, a divide whose |A| < |B|
// also finishes in IDLE with no stall.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   *E inputs           ID/EX control and data, forwarded operands SrcAE/SrcBE
//   MulDivE, MulDivOpE  RV32M select and funct3
//   FlushE, MemStallM   kill the EX instruction / hold EX/MEM
//   *M outputs          EX/MEM register contents
//   stall_o             freeze IF/ID/EX (divider busy or memory wait)
module execute_muldiv_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DIV_CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [XLEN-1:0] ALU_ResultE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            MulDivE,
  input  logic [2:0]      MulDivOpE,
  input  logic            FlushE,
  input  logic            MemStallM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM,
  output logic            stall_o
);

  localparam logic [DIV_CNT_W-1:0] CntMax = DIV_CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} div_state_e;

  div_state_e          state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]     quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, is_rem_q, is_rem_d;

  logic                regwrite_q, regwrite_d, memwrite_q, memwrite_d, resultsrc_q, resultsrc_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     pcplus4_q, pcplus4_d, wdata_q, wdata_d, result_q, result_d;

  // ---------------- multiply ----------------
  logic                 a_signed, b_signed;
  logic [2*XLEN+1:0]    a_ext, b_ext, prod;
  logic [XLEN-1:0]      mul_res;
  logic                 unused_prod;

  assign a_signed = (MulDivOpE == 3'd1) || (MulDivOpE == 3'd2);
  assign b_signed = (MulDivOpE == 3'd1);
  assign a_ext    = {{(XLEN+2){a_signed & SrcAE[XLEN-1]}}, SrcAE};
  assign b_ext    = {{(XLEN+2){b_signed & SrcBE[XLEN-1]}}, SrcBE};
  assign prod     = a_ext * b_ext;
  assign mul_res  = (MulDivOpE[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign unused_prod = ^prod[2*XLEN+1:2*XLEN];

  // ---------------- divide operand prep ----------------
  logic            div_op, div_signed, op_is_rem;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            special_hit;
  logic [XLEN-1:0] special_res;

  assign div_op     = MulDivE & MulDivOpE[2];
  assign div_signed = ~MulDivOpE[0];
  assign op_is_rem  = MulDivOpE[1];
  assign abs_a      = (div_signed && SrcAE[XLEN-1]) ? -SrcAE : SrcAE;
  assign abs_b      = (div_signed && SrcBE[XLEN-1]) ? -SrcBE : SrcBE;

  // Cases that resolve in IDLE without starting the iteration.
  always_comb begin
    special_hit = 1'b0;
    special_res = '0;
    if (SrcBE == '0) begin
      special_hit = 1'b1;
      special_res = op_is_rem ? SrcAE : '1;
    end else if (div_signed && SrcAE == {1'b1, {(XLEN-1){1'b0}}} && SrcBE == '1) begin
      special_hit = 1'b1;
      special_res = op_is_rem ? '0 : SrcAE;
    end
`ifdef DIV_EARLY_OUT_EN
    else if (abs_a < abs_b) begin
      special_hit = 1'b1;
      special_res = op_is_rem ? SrcAE : '0;
    end
`else
`endif
  end

  // ---------------- divider FSM ----------------
  logic [XLEN:0]   shifted, diff;
  logic            div_busy;
  logic [XLEN-1:0] div_final, div_res;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    div_busy  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (div_op && !FlushE && !special_hit) begin
          div_busy  = 1'b1;
          state_d   = StRun;
          cnt_d     = '0;
          quo_d     = abs_a;
          rem_d     = '0;
          dvs_d     = abs_b;
          neg_quo_d = div_signed & (SrcAE[XLEN-1] ^ SrcBE[XLEN-1]);
          neg_rem_d = div_signed & SrcAE[XLEN-1];
          is_rem_d  = op_is_rem;
        end
      end
      StRun: begin
        div_busy = 1'b1;
        // Restoring step: keep the trial difference only when it did not borrow.
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntMax) state_d = StDone;
      end
      StDone: begin
        if (!MemStallM) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A flush always wins so the killed divide can never leak a result later.
    if (FlushE) state_d = StIdle;
  end

  assign div_final = is_rem_q ? (neg_rem_q ? -rem_q : rem_q) : (neg_quo_q ? -quo_q : quo_q);
  assign div_res   = (state_q == StDone) ? div_final : special_res;
  // While reset is held the FSM is IDLE, so a pending divide must not report busy.
  assign stall_o   = (div_busy & rst) | MemStallM;

  // ---------------- EX/MEM register ----------------
  logic [XLEN-1:0] ex_result;

  assign ex_result = !MulDivE ? ALU_ResultE : (MulDivOpE[2] ? div_res : mul_res);

  always_comb begin
    regwrite_d  = regwrite_q;
    memwrite_d  = memwrite_q;
    resultsrc_d = resultsrc_q;
    rd_d        = rd_q;
    pcplus4_d   = pcplus4_q;
    wdata_d     = wdata_q;
    result_d    = result_q;
    if (MemStallM) begin
      // hold
    end else if (FlushE || div_busy) begin
      regwrite_d  = 1'b0;
      memwrite_d  = 1'b0;
      resultsrc_d = 1'b0;
      rd_d        = '0;
      pcplus4_d   = '0;
      wdata_d     = '0;
      result_d    = '0;
    end else begin
      regwrite_d  = RegWriteE;
      memwrite_d  = MemWriteE;
      resultsrc_d = ResultSrcE;
      rd_d        = RD_E;
      pcplus4_d   = PCPlus4E;
      wdata_d     = WriteDataE;
      result_d    = ex_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      is_rem_q    <= 1'b0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      rd_q        <= '0;
      pcplus4_q   <= '0;
      wdata_q     <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      is_rem_q    <= is_rem_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      pcplus4_q   <= pcplus4_d;
      wdata_q     <= wdata_d;
      result_q    <= result_d;
    end
  end

  assign RegWriteM   = regwrite_q;
  assign MemWriteM   = memwrite_q;
  assign ResultSrcM  = resultsrc_q;
  assign RD_M        = rd_q;
  assign PCPlus4M    = pcplus4_q;
  assign WriteDataM  = wdata_q;
  assign ALU_ResultM = result_q;

endmodule

// File: tb/tb_execute_muldiv_stage.sv
// Self-checking bench for execute_muldiv_stage: directed vector table, random transactions
// against an arithmetic reference model, and hand-written flush / memory-stall / reset cases.
module tb_execute_muldiv_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE;
  logic [4:0]  RD_E;
  logic [31:0] PCPlus4E, WriteDataE, ALU_ResultE, SrcAE, SrcBE;
  logic        MulDivE;
  logic [2:0]  MulDivOpE;
  logic        FlushE, MemStallM;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        stall_o;

  int total = 0;
  int bad   = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EarlyStall = 0;
`else
  localparam int EarlyStall = 33;
`endif

  execute_muldiv_stage dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .ResultSrcE  (ResultSrcE),
    .RD_E        (RD_E),
    .PCPlus4E    (PCPlus4E),
    .WriteDataE  (WriteDataE),
    .ALU_ResultE (ALU_ResultE),
    .SrcAE       (SrcAE),
    .SrcBE       (SrcBE),
    .MulDivE     (MulDivE),
    .MulDivOpE   (MulDivOpE),
    .FlushE      (FlushE),
    .MemStallM   (MemStallM),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .WriteDataM  (WriteDataM),
    .ALU_ResultM (ALU_ResultM),
    .stall_o     (stall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model, written from the RV32M arithmetic rules.
  function automatic logic [31:0] model_res(bit md, logic [2:0] op, logic [31:0] a,
                                            logic [31:0] b, logic [31:0] alu);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (!md) return alu;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_stall(bit md, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] aa, bb;
    bit sgn;
    if (!md || !op[2]) return 0;
    if (b == 0) return 0;
    sgn = !op[0];
    if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
    aa = (sgn && a[31]) ? -a : a;
    bb = (sgn && b[31]) ? -b : b;
    if (aa < bb) return EarlyStall;
    return 33;
  endfunction

  // Issue one instruction right after a posedge and follow it into EX/MEM.
  task automatic do_txn(input string name, input bit md, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] alu,
                        input logic [31:0] exp_res, input int exp_stall);
    int stalls;
    bit bub_ok, done;
    logic [39:0] side;
    MulDivE = md; MulDivOpE = op; SrcAE = a; SrcBE = b; ALU_ResultE = alu;
    RegWriteE = 1'b1; MemWriteE = 1'($urandom); ResultSrcE = 1'($urandom);
    RD_E = 5'($urandom); PCPlus4E = $urandom; WriteDataE = $urandom;
    side = {1'b0, MemWriteE, ResultSrcE, RD_E, PCPlus4E[31:0]};
    stalls = 0; bub_ok = 1'b1; done = 1'b0;
    while (!done && stalls < 100) begin
      @(negedge clk);
      if (!stall_o) done = 1'b1;
      else begin
        if (stalls > 0 && RegWriteM) bub_ok = 1'b0;
        stalls++;
      end
    end
    if (!done) begin
      check({name, " timeout"}, 64'(stalls), 64'(exp_stall));
      return;
    end
    @(posedge clk); #1;
    check({name, " result"}, 64'(ALU_ResultM), 64'(exp_res));
    check({name, " stall cycles"}, 64'(stalls), 64'(exp_stall));
    check({name, " fields"}, {RegWriteM, 1'b0, MemWriteM, ResultSrcM, RD_M, PCPlus4M,
                              WriteDataM}, {1'b1, side, WriteDataE});
    if (exp_stall > 0) check({name, " bubble"}, 64'(bub_ok), 64'd1);
  endtask

  typedef struct {
    string       name;
    bit          md;
    logic [2:0]  op;
    logic [31:0] a, b, alu, res;
    int          stall;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{"alu pass",    1'b0, 3'd4, 32'h7, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 0};
    vecs[1]  = '{"mul",         1'b1, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000001, 0};
    vecs[2]  = '{"mulh",        1'b1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000000, 0};
    vecs[3]  = '{"mulhu",       1'b1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 0};
    vecs[4]  = '{"mulhsu",      1'b1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 0};
    vecs[5]  = '{"div -7/2",    1'b1, 3'd4, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFD, 33};
    vecs[6]  = '{"rem -7/2",    1'b1, 3'd6, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFF, 33};
    vecs[7]  = '{"divu 100/7",  1'b1, 3'd5, 32'd100, 32'd7, 32'h0, 32'd14, 33};
    vecs[8]  = '{"div x/0",     1'b1, 3'd4, 32'h12345678, 32'd0, 32'h0, 32'hFFFFFFFF, 0};
    vecs[9]  = '{"remu 5/0",    1'b1, 3'd7, 32'd5, 32'd0, 32'h0, 32'd5, 0};
    vecs[10] = '{"div ovf",     1'b1, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0};
    vecs[11] = '{"divu 3/9",    1'b1, 3'd5, 32'd3, 32'd9, 32'h0, 32'd0, EarlyStall};
    vecs[12] = '{"remu 3/9",    1'b1, 3'd7, 32'd3, 32'd9, 32'h0, 32'd3, EarlyStall};
    vecs[13] = '{"rem neg div", 1'b1, 3'd6, 32'd7, 32'hFFFFFFFE, 32'h0, 32'd1, 33};

    rst = 1'b0;
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; RD_E = 0; PCPlus4E = 0; WriteDataE = 0;
    ALU_ResultE = 0; SrcAE = 0; SrcBE = 0; MulDivE = 0; MulDivOpE = 0; FlushE = 0;
    MemStallM = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ctrl", {RegWriteM, MemWriteM, ResultSrcM, RD_M}, 0);
    check("reset data", {PCPlus4M, WriteDataM}, 0);
    check("reset result", ALU_ResultM, 0);
    check("reset stall", stall_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      do_txn(vecs[i].name, vecs[i].md, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].alu,
             vecs[i].res, vecs[i].stall);

    // Random transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      bit md;
      logic [2:0] op;
      logic [31:0] a, b, alu;
      md  = ($urandom_range(0, 3) != 0);
      op  = 3'($urandom_range(0, 7));
      alu = $urandom;
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      do_txn("random", md, op, a, b, alu, model_res(md, op, a, b, alu),
             model_stall(md, op, a, b));
    end

    // Flush while the divider is at cnt = 10.
    MulDivE = 1; MulDivOpE = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd3; RegWriteE = 1;
    repeat (11) @(posedge clk);
    #1 FlushE = 1'b1;
    @(negedge clk);
    check("flush busy before edge", stall_o, 1);
    @(posedge clk); #1;
    FlushE = 1'b0; MulDivE = 1'b0; ALU_ResultE = 32'h1234;
    check("flush bubble", RegWriteM, 0);
    check("flush stall drop", stall_o, 0);
    @(posedge clk); #1;
    check("after flush result", ALU_ResultM, 32'h1234);
    check("after flush regwrite", RegWriteM, 1);

    // Memory stall held for three cycles while the divider is in DONE.
    MulDivE = 1; MulDivOpE = 3'd5; SrcAE = 32'd100; SrcBE = 32'd7;
    repeat (33) @(posedge clk);
    #1;
    check("done no div stall", stall_o, 0);
    MemStallM = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("memstall frozen result", ALU_ResultM, 0);
      check("memstall frozen regwrite", RegWriteM, 0);
      check("memstall stall_o", stall_o, 1);
    end
    MemStallM = 1'b0;
    @(posedge clk); #1;
    MulDivE = 1'b0; ALU_ResultE = 32'h55;
    check("memstall released result", ALU_ResultM, 32'd14);
    check("memstall released regwrite", RegWriteM, 1);
    @(posedge clk); #1;
    check("post memstall alu", ALU_ResultM, 32'h55);

    // Reset pulse in the middle of RUN.
    MulDivE = 1; MulDivOpE = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd3;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid reset outputs", {RegWriteM, RD_M, ALU_ResultM}, 0);
    check("mid reset stall", stall_o, 0);
    @(posedge clk); #1;
    MulDivE = 1'b0; ALU_ResultE = 32'hBEEF; rst = 1'b1;
    #1;
    check("after reset idle", stall_o, 0);
    @(posedge clk); #1;
    check("after reset alu", ALU_ResultM, 32'hBEEF);

    // Back-to-back divides after the reset.
    do_txn("b2b div 1", 1'b1, 3'd4, 32'd1000, 32'hFFFFFFFD, 32'h0, 32'hFFFFFEB3, 33);
    do_txn("b2b rem 2", 1'b1, 3'd6, 32'd1000, 32'hFFFFFFFD, 32'h0, 32'd1, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
